// File: rtl/alu_iter_m_if.sv
// alu_iter_m_if: request/response bundle for the iterative RV32I/M execute unit.
//   master : decode/writeback side; drives op/operands and out_ready
//   slave  : the execute unit; drives in_ready, result and flags
//   in_valid/in_ready : operation handshake (op, op_a, op_b)
//   out_valid/out_ready : result handshake (result, zero, illegal)
interface alu_iter_m_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   modport master (
      output in_valid, op, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, op, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_iter_m.sv
// alu_iter_m: RV32I/M execute unit. Base ops complete in one cycle; M-extension
// multiply/divide iterate one bit per cycle on operand magnitudes, then fix up sign.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   flush    : synchronous abort of any op in flight (blocks accept that cycle)
//   bus      : slave side of alu_iter_m_if (op in, result out, valid/ready both ways)
//   busy     : unit not idle
module alu_iter_m #(
   parameter int XLEN = 32,
   parameter bit M_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   alu_iter_m_if.slave  bus,
   output logic         busy
);
   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
   state_t state, nxt;

   logic [XLEN-1:0]   a, b;
   logic [2:0]        f3;
   logic [SW-1:0]     shamt;
   logic              in_rdy, accept;

   logic [XLEN-1:0]   imm_res;
   logic              imm_ill, go_mul, go_div;
   logic              a_sgn, b_sgn, sa, sb;
   logic [XLEN-1:0]   mag_a, mag_b;

   logic [2*XLEN-1:0] acc, mul_step, div_step, prod;
   logic [XLEN-1:0]   dvs, dv, fix_res;
   logic [XLEN:0]     msum, ddiff;
   logic [SW-1:0]     cnt;
   logic              neg;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   res_q;
   logic              zero_q, ill_q;

   assign a     = bus.op_a;
   assign b     = bus.op_b;
   assign f3    = bus.op[2:0];
   assign shamt = b[SW-1:0];

   // Decode at accept: one-cycle result (base op, illegal, or M special case)
   // unless the op needs the iterative multiplier or divider.
   always_comb begin
      imm_res = '0;
      imm_ill = 1'b0;
      go_mul  = 1'b0;
      go_div  = 1'b0;
      if (!bus.op[4] || !M_EN) begin
         if (bus.op[4]) imm_ill = 1'b1;
         else begin
            case (bus.op[3:0])
               4'b0000: imm_res = a + b;
               4'b1000: imm_res = a - b;
               4'b0001: imm_res = a << shamt;
               4'b0010: imm_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
               4'b0011: imm_res = {{(XLEN-1){1'b0}}, (a < b)};
               4'b0100: imm_res = a ^ b;
               4'b0101: imm_res = a >> shamt;
               4'b1101: imm_res = $signed(a) >>> shamt;
               4'b0110: imm_res = a | b;
               4'b0111: imm_res = a & b;
               4'b1111: imm_res = b;
               default: imm_ill = 1'b1;
            endcase
         end
      end else if (!f3[2]) begin
         go_mul = 1'b1;
      end else if (b == '0) begin
         imm_res = f3[1] ? a : '1;
      end else if (!f3[0] && a == MINV && b == '1) begin
         // signed overflow: quotient wraps to the dividend, remainder is 0
         imm_res = f3[1] ? '0 : a;
      end else begin
         go_div = 1'b1;
      end
   end

   // Operand signedness: mul/mulh s*s, mulhsu s*u, mulhu u*u; div/rem signed when f3[0]=0.
   always_comb begin
      a_sgn = f3[2] ? !f3[0] : (f3[1:0] != 2'b11);
      b_sgn = f3[2] ? !f3[0] : !f3[1];
      sa    = a_sgn & a[XLEN-1];
      sb    = b_sgn & b[XLEN-1];
      mag_a = sa ? -a : a;
      mag_b = sb ? -b : b;
   end

   // One shift-add / restoring-subtract step on the shared accumulator.
   // MUL: acc = {partial product, remaining multiplier bits}.
   // DIV: acc = {partial remainder, remaining dividend / quotient bits}.
   always_comb begin
      msum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, dvs};
      mul_step = acc[0] ? {msum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
      ddiff    = acc[2*XLEN-1:XLEN-1] - {1'b0, dvs};
      div_step = ddiff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                             : {ddiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      prod     = neg ? -acc : acc;
      dv       = f3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (f3_q[2]) fix_res = neg ? -dv : dv;
      else         fix_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt    = state;
      in_rdy = !flush && (state == IDLE || (state == DONE && bus.out_ready));
      accept = bus.in_valid && in_rdy;
      case (state)
         MUL, DIV: if (cnt == '0) nxt = FIX;
         FIX:      nxt = DONE;
         DONE:     if (bus.out_ready) nxt = IDLE;
         default:  ;
      endcase
      if (accept) nxt = go_mul ? MUL : (go_div ? DIV : DONE);
      if (flush)  nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         dvs    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         f3_q   <= '0;
         res_q  <= '0;
         zero_q <= 1'b1;
         ill_q  <= 1'b0;
      end else if (accept) begin
         f3_q <= f3;
         cnt  <= SW'(XLEN-1);
         if (go_mul) begin
            dvs <= mag_a;
            acc <= {{XLEN{1'b0}}, mag_b};
            neg <= sa ^ sb;
         end else if (go_div) begin
            dvs <= mag_b;
            acc <= {{XLEN{1'b0}}, mag_a};
            neg <= f3[1] ? sa : (sa ^ sb);   // remainder follows the dividend
         end else begin
            res_q  <= imm_res;
            zero_q <= (imm_res == '0);
            ill_q  <= imm_ill;
         end
      end else if (state == MUL || state == DIV) begin
         acc <= (state == MUL) ? mul_step : div_step;
         cnt <= cnt - SW'(1);
      end else if (state == FIX && !flush) begin
         res_q  <= fix_res;
         zero_q <= (fix_res == '0);
         ill_q  <= 1'b0;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = (state == DONE);
   assign bus.result    = res_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = ill_q;
   assign busy          = (state != IDLE);
endmodule
